// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage and a combinational imem.
// The fetch stage is the master: it drives the address and samples the data.
interface if_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;

   modport master (
      output imem_addr,
      input  imem_instr
   );

   modport slave (
      input  imem_addr,
      output imem_instr
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and fetch counter.
// Honours decode-side stall and branch flush/redirect; flush beats stall.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          COUNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic [31:0]        branch_target_i,
   if_stage_if.master         imem,
   output logic [31:0]        pc_o,
   output logic [31:0]        ifid_pc_o,
   output logic [31:0]        ifid_instr_o,
   output logic               ifid_valid_o,
   output logic [COUNT_W-1:0] fetch_count_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic do_flush;
   logic do_adv;

   logic [31:0] target_aligned;
   logic        unused_target_lsbs;

   // Redirects are forced to word alignment; the low bits are dropped.
   assign target_aligned     = {branch_target_i[31:2], 2'b00};
   assign unused_target_lsbs = ^branch_target_i[1:0];

   assign imem.imem_addr = pc_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_i) state_d = RUN;
         RUN:  if (!start_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      do_flush = 1'b0;
      do_adv   = 1'b0;
      unique case (state_q)
         RUN: begin
            do_flush = start_i & flush_i;
            do_adv   = start_i & ~flush_i & ~stall_i;
         end
         default: begin
            do_flush = 1'b0;
            do_adv   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_o          <= RESET_PC;
         ifid_pc_o     <= 32'h0;
         ifid_instr_o  <= NOP_INSTR;
         ifid_valid_o  <= 1'b0;
         fetch_count_o <= '0;
      end else if (do_flush) begin
         pc_o         <= target_aligned;
         ifid_pc_o    <= 32'h0;
         ifid_instr_o <= NOP_INSTR;
         ifid_valid_o <= 1'b0;
      end else if (do_adv) begin
         pc_o         <= pc_o + 32'd4;
         ifid_pc_o    <= pc_o;
         ifid_instr_o <= imem.imem_instr;
         ifid_valid_o <= 1'b1;
         // Counter sticks at all-ones instead of wrapping.
         if (fetch_count_o != '1) begin
            fetch_count_o <= fetch_count_o + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, flush, start drop, reset, wrap.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] target = 32'h0;

   logic [31:0] pc, ifid_pc, ifid_instr;
   logic        ifid_valid;
   logic [31:0] fcount;

   logic [31:0] s_pc, s_ifid_pc, s_ifid_instr;
   logic        s_ifid_valid;
   logic [1:0]  s_fcount;

   int errors = 0;
   int checks = 0;

   if_stage_if bus ();
   if_stage_if sbus ();

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_model(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h00A0_0093;
         32'h0000_0004: return 32'h0010_0113;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   always_comb bus.imem_instr  = imem_model(bus.imem_addr);
   always_comb sbus.imem_instr = imem_model(sbus.imem_addr);

   if_stage dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .stall_i         (stall),
      .flush_i         (flush),
      .branch_target_i (target),
      .imem            (bus.master),
      .pc_o            (pc),
      .ifid_pc_o       (ifid_pc),
      .ifid_instr_o    (ifid_instr),
      .ifid_valid_o    (ifid_valid),
      .fetch_count_o   (fcount)
   );

   if_stage #(.COUNT_W(2)) dut_sat (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .stall_i         (stall),
      .flush_i         (flush),
      .branch_target_i (target),
      .imem            (sbus.master),
      .pc_o            (s_pc),
      .ifid_pc_o       (s_ifid_pc),
      .ifid_instr_o    (s_ifid_instr),
      .ifid_valid_o    (s_ifid_valid),
      .fetch_count_o   (s_fcount)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag,
                             input logic [31:0] e_pc,
                             input logic [31:0] e_ipc,
                             input logic [31:0] e_instr,
                             input logic        e_valid,
                             input logic [31:0] e_cnt);
      check({tag, ".pc"},    pc,                 e_pc);
      check({tag, ".addr"},  bus.imem_addr,      e_pc);
      check({tag, ".ifpc"},  ifid_pc,            e_ipc);
      check({tag, ".instr"}, ifid_instr,         e_instr);
      check({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, e_valid});
      check({tag, ".cnt"},   fcount,             e_cnt);
   endtask

   initial begin
      // Reset
      tick();
      check_ifid("rst", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0);
      check("rst.scnt", {30'h0, s_fcount}, 32'd0);

      // Start: edge 1 enters RUN, edge 2 first fetch
      rst = 1'b0;
      start = 1'b1;
      tick();
      check_ifid("e1", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0);
      tick();
      check_ifid("e2", 32'h4, 32'h0, 32'h00A0_0093, 1'b1, 32'd1);
      tick();
      check_ifid("e3", 32'h8, 32'h4, 32'h0010_0113, 1'b1, 32'd2);

      // Stall two edges at pc=8
      stall = 1'b1;
      tick();
      check_ifid("st1", 32'h8, 32'h4, 32'h0010_0113, 1'b1, 32'd2);
      tick();
      check_ifid("st2", 32'h8, 32'h4, 32'h0010_0113, 1'b1, 32'd2);
      stall = 1'b0;
      tick();
      check_ifid("strel", 32'hC, 32'h8, 32'h5A5A_0008, 1'b1, 32'd3);

      // Flush and stall together: flush wins
      flush = 1'b1;
      stall = 1'b1;
      target = 32'h43;
      tick();
      check_ifid("fl", 32'h40, 32'h0, 32'h13, 1'b0, 32'd3);
      flush = 1'b0;
      stall = 1'b0;
      tick();
      check_ifid("fl+1", 32'h44, 32'h40, 32'h5A5A_0040, 1'b1, 32'd4);
      check("fl+1.scnt", {30'h0, s_fcount}, 32'd3);

      // Get a valid instruction at 0xC with pc=0x10
      flush = 1'b1;
      target = 32'hC;
      tick();
      flush = 1'b0;
      tick();
      check_ifid("pre", 32'h10, 32'hC, 32'h5A5A_000C, 1'b1, 32'd5);
      check("pre.scnt", {30'h0, s_fcount}, 32'd3);

      // Drop start for 3 edges; flush/stall in IDLE are ignored
      start = 1'b0;
      tick();
      check_ifid("drop1", 32'h10, 32'hC, 32'h5A5A_000C, 1'b1, 32'd5);
      flush = 1'b1;
      stall = 1'b1;
      target = 32'h100;
      tick();
      check_ifid("drop2", 32'h10, 32'hC, 32'h5A5A_000C, 1'b1, 32'd5);
      flush = 1'b0;
      stall = 1'b0;
      tick();
      check_ifid("drop3", 32'h10, 32'hC, 32'h5A5A_000C, 1'b1, 32'd5);
      start = 1'b1;
      tick();
      check_ifid("rerun", 32'h10, 32'hC, 32'h5A5A_000C, 1'b1, 32'd5);
      tick();
      check_ifid("resume", 32'h14, 32'h10, 32'h5A5A_0010, 1'b1, 32'd6);

      // Reach pc=0x20 with a live instruction, then reset mid-run
      flush = 1'b1;
      target = 32'h1C;
      tick();
      flush = 1'b0;
      tick();
      check_ifid("pre_rst", 32'h20, 32'h1C, 32'h5A5A_001C, 1'b1, 32'd7);
      rst = 1'b1;
      flush = 1'b1;
      stall = 1'b1;
      target = 32'h80;
      tick();
      check_ifid("mrst", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0);
      check("mrst.scnt", {30'h0, s_fcount}, 32'd0);
      rst = 1'b0;
      flush = 1'b0;
      stall = 1'b0;
      tick();
      check_ifid("mrst.idle", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0);
      tick();
      check_ifid("mrst.run", 32'h4, 32'h0, 32'h00A0_0093, 1'b1, 32'd1);

      // PC wrap at the top of the address space
      flush = 1'b1;
      target = 32'hFFFF_FFFF;
      tick();
      check_ifid("wrap.fl", 32'hFFFF_FFFC, 32'h0, 32'h13, 1'b0, 32'd1);
      flush = 1'b0;
      tick();
      check_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'hA5A5_FFFC, 1'b1, 32'd2);

      // Narrow counter: 4 more fetches push 2-bit count past all-ones
      repeat (4) tick();
      check("sat.cnt", fcount, 32'd6);
      check("sat.scnt", {30'h0, s_fcount}, 32'd3);
      check("sat.spc", s_pc, 32'h10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode (Control, Registers, ImmGen).
- Owns the PC, drives the instruction memory read address, and hands decode a registered instruction/PC pair with a valid bit.
- Obeys hazard-detection stalls and branch flush/redirect from the decode stage.
- Keeps a fetch counter for bench/debug visibility.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset/flush.
COUNT_W, 32, width of the fetched-instruction counter.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  reset; synchronous, active-high.
start_i  input  1  run enable (level); fetch advances only while high.
stall_i  input  1  hazard stall from Hazard_Detection; hold PC and IF/ID.
flush_i  input  1  taken branch resolved in ID; redirect PC and squash IF/ID.
branch_target_i  input  32  redirect address, valid with flush_i.
imem_addr_o  output  32  instruction memory address; combinational copy of PC.
imem_instr_i  input  32  instruction memory read data (combinational memory).
pc_o  output  32  current PC register.
ifid_pc_o  output  32  PC of instruction held in IF/ID.
ifid_instr_o  output  32  instruction held in IF/ID.
ifid_valid_o  output  1  IF/ID holds a real fetched instruction.
fetch_count_o  output  COUNT_W  number of instructions latched into IF/ID.

Behaviour:
- Reset (rst_i=1 at edge, overrides everything, including mid-run): state=IDLE, pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, fetch_count=0.
- imem_addr_o = pc_o, with zero added latency; the instruction for PC is sampled from imem_instr_i at the same edge.
- FSM states IDLE and RUN.
  - IDLE: no register changes. stall_i and flush_i are ignored. If start_i=1, go to RUN at that edge; the first fetch latches on the following edge.
  - RUN with start_i=0: go to IDLE and hold all registers unchanged (no clearing). Resuming continues from the held PC.
- RUN with start_i=1, per-edge priority flush_i > stall_i > advance:
  - Flush: pc <= {branch_target_i[31:2],2'b00}; ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc <= 0; counter unchanged.
  - Stall: pc, ifid_pc, ifid_instr, ifid_valid and counter all hold.
  - Advance: ifid_pc <= pc; ifid_instr <= imem_instr_i; ifid_valid <= 1; pc <= pc+4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0); fetch_count saturates at all-ones, otherwise +1.
- Simultaneous flush_i and stall_i: flush wins, because the stalled instruction is on the squashed path.
- Latency: an instruction at address A appears on ifid_instr_o one edge after pc_o==A with no stall.
- Branch penalty: 1 bubble after flush.
- All outputs are registered except imem_addr_o.

Test Plan:
- Reset then start_i=1 held, imem returns 0x00A00093 at addr 0 and 0x00100113 at addr 4. Required: edge 1 enters RUN; edge 2 gives ifid=(pc 0, 0x00A00093, valid 1) and pc_o=4; edge 3 gives ifid=(4, 0x00100113) and fetch_count=2.
- stall_i=1 for 2 edges at pc=8. Required: pc_o stays 8, ifid and fetch_count unchanged. After release, the next edge latches the addr-8 instruction and pc_o=12.
- flush_i=1 with branch_target_i=0x43 and stall_i=1 in the same cycle. Required: pc_o=0x40, ifid_instr=0x00000013, ifid_valid=0, counter unchanged. The next edge latches from 0x40.
- start_i dropped at pc=0x10 for 3 edges, then raised. Required: registers frozen during the drop; one edge to re-enter RUN; fetch resumes at 0x10.
- rst_i pulsed mid-run at pc=0x20. Required: pc_o=RESET_PC, ifid_valid=0, fetch_count=0, state IDLE. The stall_i and flush_i asserted during reset have no effect.
- pc forced to 0xFFFFFFFC via flush, then one advance. Required: pc_o=0, ifid_pc_o=0xFFFFFFFC.
